// File: rtl/ad1939_adc_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : ad1939_adc_deserializer
// Purpose  : AD1939 ADC serial (I2S / left-justified) to Avalon-ST stereo samples,
//            codec clocks oversampled in clk. Macro AD1939_ADC_LJ_EN selects LJ.
// Revision : 1.0 - initial release
// ============================================================================
module ad1939_adc_deserializer #(
   parameter int DATA_W      = 24,
   parameter int SLOT_W      = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              adc_bclk,
   input  logic              adc_lrclk,
   input  logic              adc_sdata,
   output logic [DATA_W-1:0] avalon_st_data,
   output logic              avalon_st_channel,
   output logic              avalon_st_valid,
   input  logic              avalon_st_ready,
   input  logic              status_clear,
   output logic              overrun,
   output logic              framing_err
);

   localparam int               CNT_W      = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
   localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(DATA_W - 1);

   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_delay = 2'd1;
   localparam logic [1:0] c_shift = 2'd2;
   localparam logic [1:0] c_pad   = 2'd3;

`ifdef AD1939_ADC_LJ_EN
   localparam logic [1:0] c_restart = c_shift;
`else
   localparam logic [1:0] c_restart = c_delay;
`endif

   logic [SYNC_STAGES-1:0] r_bclk_sync;
   logic [SYNC_STAGES-1:0] r_lr_sync;
   logic [SYNC_STAGES-1:0] r_sd_sync;
   logic                   r_bclk_d;
   logic                   r_lr_d;
   logic                   r_sd_d;
   logic                   r_bclk_rise;
   logic                   r_lr_edge;

   // Synchronizers free-run through reset so a level already present at
   // release is never mistaken for an LRCLK edge.
   always_ff @(posedge clk) begin
      r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], adc_bclk};
      r_lr_sync   <= {r_lr_sync[SYNC_STAGES-2:0], adc_lrclk};
      r_sd_sync   <= {r_sd_sync[SYNC_STAGES-2:0], adc_sdata};
      r_bclk_d    <= r_bclk_sync[SYNC_STAGES-1];
      r_lr_d      <= r_lr_sync[SYNC_STAGES-1];
      r_sd_d      <= r_sd_sync[SYNC_STAGES-1];
      if (reset) begin
         r_bclk_rise <= 1'b0;
         r_lr_edge   <= 1'b0;
      end else begin
         r_bclk_rise <= r_bclk_sync[SYNC_STAGES-1] & ~r_bclk_d;
         r_lr_edge   <= r_lr_sync[SYNC_STAGES-1] ^ r_lr_d;
      end
   end

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_shift;
   logic              r_slot_ch;
   logic              r_done;
   logic              r_done_ch;
   logic              w_take;
   logic              w_last;

   assign w_take = (r_state == c_shift) && r_bclk_rise;
   assign w_last = w_take && (r_cnt == c_last_bit);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= c_idle;
         r_cnt       <= '0;
         r_shift     <= '0;
         r_slot_ch   <= 1'b0;
         r_done      <= 1'b0;
         r_done_ch   <= 1'b0;
         framing_err <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_last)
            r_done_ch <= r_slot_ch;
         if (w_take)
            r_shift <= (r_shift << 1) | DATA_W'(r_sd_d);

         // A final bit arriving with the LRCLK edge still completes its word.
         if (r_lr_edge) begin
            r_slot_ch <= r_lr_d;
            r_cnt     <= '0;
            r_state   <= c_restart;
         end else begin
            case (r_state)
               c_delay: if (r_bclk_rise) r_state <= c_shift;
               c_shift: begin
                  if (r_bclk_rise) begin
                     if (w_last)
                        r_state <= c_pad;
                     else
                        r_cnt <= r_cnt + 1'b1;
                  end
               end
               default: r_state <= r_state;
            endcase
         end

         if (r_lr_edge && (r_state == c_shift) && !w_last)
            framing_err <= 1'b1;
         else if (status_clear)
            framing_err <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         avalon_st_data    <= '0;
         avalon_st_channel <= 1'b0;
         avalon_st_valid   <= 1'b0;
         overrun           <= 1'b0;
      end else begin
         if (r_done) begin
            avalon_st_data    <= r_shift;
            avalon_st_channel <= r_done_ch;
            avalon_st_valid   <= 1'b1;
         end else if (avalon_st_valid && avalon_st_ready) begin
            avalon_st_valid <= 1'b0;
         end

         if (r_done && avalon_st_valid && !avalon_st_ready)
            overrun <= 1'b1;
         else if (status_clear)
            overrun <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ad1939_adc_deserializer.sv
`default_nettype none
// Bench for ad1939_adc_deserializer: directed + random codec slots checked against
// a bit-level slot model (format follows AD1939_ADC_LJ_EN).
module tb_ad1939_adc_deserializer;

   localparam int DATA_W      = 24;
   localparam int SLOT_W      = 32;
   localparam int SYNC_STAGES = 2;
`ifdef AD1939_ADC_LJ_EN
   localparam int          OFF    = 0;
   localparam logic [31:0] LJ_EXP = 32'h800000;
`else
   localparam int          OFF    = 1;
   localparam logic [31:0] LJ_EXP = 32'h000001;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              adc_bclk = 1'b0;
   logic              adc_lrclk = 1'b0;
   logic              adc_sdata = 1'b0;
   logic              avalon_st_ready = 1'b1;
   logic              status_clear = 1'b0;
   logic [DATA_W-1:0] avalon_st_data;
   logic              avalon_st_channel;
   logic              avalon_st_valid;
   logic              overrun;
   logic              framing_err;

   ad1939_adc_deserializer #(
      .DATA_W(DATA_W), .SLOT_W(SLOT_W), .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk(clk), .reset(reset),
      .adc_bclk(adc_bclk), .adc_lrclk(adc_lrclk), .adc_sdata(adc_sdata),
      .avalon_st_data(avalon_st_data), .avalon_st_channel(avalon_st_channel),
      .avalon_st_valid(avalon_st_valid), .avalon_st_ready(avalon_st_ready),
      .status_clear(status_clear), .overrun(overrun), .framing_err(framing_err)
   );

   always #5 clk = ~clk;

   int              total = 0;
   int              bad = 0;
   int              cyc = 0;
   int              clr_cyc = -1;
   int              lsb_cyc = 0;
   bit              rnd_ready = 1'b0;
   bit              prev_lr = 1'b0;
   bit              frag = 1'b0;
   bit              fe_exp = 1'b0;
   bit              slot_bits [SLOT_W];
   logic [DATA_W:0] exp_q [$];
   logic            last_valid = 1'b0;
   logic            last_acc = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
      status_clear = (cyc == clr_cyc);
      if (rnd_ready) avalon_st_ready = 1'($urandom);
   endtask

   task automatic fill_slot(input logic [DATA_W-1:0] word, input int off);
      for (int i = 0; i < SLOT_W; i++) slot_bits[i] = 1'($urandom);
      for (int b = 0; b < DATA_W; b++) slot_bits[off+b] = word[DATA_W-1-b];
   endtask

   // One LRCLK half-period: bit i is driven on the BCLK falling edge, 8 clk per bit.
   task automatic send_slot(input bit lr, input int nbits, input int rst_rel, input bit clr_at_done);
      bit              seen;
      logic [DATA_W-1:0] w;
      tick();
      seen    = (lr != prev_lr) && !reset;
      prev_lr = lr;
      if (seen) begin
         if (frag) fe_exp = 1'b1;
         frag = (nbits >= OFF) && (nbits < OFF + DATA_W);
      end
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_rel) reset = 1'b0;
         adc_bclk  = 1'b0;
         adc_lrclk = lr;
         adc_sdata = slot_bits[i];
         repeat (4) tick();
         adc_bclk = 1'b1;
         if (seen && i == OFF + DATA_W - 1) begin
            for (int b = 0; b < DATA_W; b++) w[DATA_W-1-b] = slot_bits[OFF+b];
            exp_q.push_back({lr, w});
            lsb_cyc = cyc + 1;
            if (clr_at_done) clr_cyc = cyc + SYNC_STAGES + 2;
         end
         repeat (4) tick();
      end
   endtask

   task automatic clear_pulse();
      clr_cyc = cyc + 1;
      tick();
      tick();
   endtask

   // Only the newest unaccepted word survives in the holding register.
   task automatic collapse_queue();
      while (exp_q.size() > 1) void'(exp_q.pop_front());
   endtask

   always @(negedge clk) begin
      logic [DATA_W:0] e;
      if (avalon_st_valid && !last_valid)
         chk("latency", cyc, lsb_cyc + SYNC_STAGES + 2);
      if (last_acc)
         chk("valid_one_cycle", 32'(avalon_st_valid), 32'(1'b0));
      if (avalon_st_valid && avalon_st_ready) begin
         if (exp_q.size() == 0) begin
            chk("spurious_valid", 32'(avalon_st_valid), 32'(1'b0));
         end else begin
            e = exp_q.pop_front();
            chk("data", 32'(avalon_st_data), 32'(e[DATA_W-1:0]));
            chk("channel", 32'(avalon_st_channel), 32'(e[DATA_W]));
         end
      end
      last_valid = avalon_st_valid;
      last_acc   = avalon_st_valid && avalon_st_ready;
   end

   initial begin
      logic [DATA_W:0] e;
      bit              ov;

      repeat (10) tick();
      reset = 1'b0;
      tick();
      @(negedge clk);
      chk("rst_data", 32'(avalon_st_data), 32'h0);
      chk("rst_channel", 32'(avalon_st_channel), 32'h0);
      chk("rst_valid", 32'(avalon_st_valid), 32'h0);
      chk("rst_overrun", 32'(overrun), 32'h0);
      chk("rst_framing", 32'(framing_err), 32'h0);

      fill_slot(DATA_W'($urandom), OFF); send_slot(1'b1, SLOT_W, -1, 1'b0);
      fill_slot(24'h123456, OFF);        send_slot(1'b0, SLOT_W, -1, 1'b0);
      fill_slot(24'hABCDEF, OFF);        send_slot(1'b1, SLOT_W, -1, 1'b0);
      @(negedge clk);
      chk("basic_drained", exp_q.size(), 0);
      chk("basic_overrun", 32'(overrun), 32'h0);
      chk("basic_framing", 32'(framing_err), 32'(fe_exp));

      tick();
      avalon_st_ready = 1'b0;
      fill_slot(24'h000001, OFF); send_slot(1'b0, SLOT_W, -1, 1'b0);
      fill_slot(24'h000002, OFF); send_slot(1'b1, SLOT_W, -1, 1'b0);
      @(negedge clk);
      e  = exp_q[exp_q.size()-1];
      ov = exp_q.size() > 1;
      chk("hold_valid", 32'(avalon_st_valid), 32'h1);
      chk("hold_data", 32'(avalon_st_data), 32'(e[DATA_W-1:0]));
      chk("hold_channel", 32'(avalon_st_channel), 32'(e[DATA_W]));
      chk("overrun_set", 32'(overrun), 32'(ov));
      collapse_queue();
      clear_pulse();
      @(negedge clk);
      chk("overrun_cleared", 32'(overrun), 32'h0);
      chk("valid_after_clear", 32'(avalon_st_valid), 32'h1);

      fill_slot(DATA_W'($urandom), OFF); send_slot(1'b0, SLOT_W, -1, 1'b1);
      @(negedge clk);
      e  = exp_q[exp_q.size()-1];
      ov = exp_q.size() > 1;
      chk("overrun_set_wins", 32'(overrun), 32'(ov));
      chk("overwrite_data", 32'(avalon_st_data), 32'(e[DATA_W-1:0]));
      collapse_queue();
      tick();
      avalon_st_ready = 1'b1;
      clear_pulse();
      @(negedge clk);
      chk("ovr_drained", exp_q.size(), 0);
      chk("ovr_flag_off", 32'(overrun), 32'h0);

      fill_slot(DATA_W'($urandom), OFF); send_slot(1'b1, 10, -1, 1'b0);
      fill_slot(DATA_W'($urandom), OFF); send_slot(1'b0, SLOT_W, -1, 1'b0);
      @(negedge clk);
      chk("framing_set", 32'(framing_err), 32'(fe_exp));
      chk("framing_drained", exp_q.size(), 0);
      clear_pulse();
      fe_exp = 1'b0;
      @(negedge clk);
      chk("framing_cleared", 32'(framing_err), 32'(fe_exp));

      tick();
      reset  = 1'b1;
      frag   = 1'b0;
      fe_exp = 1'b0;
      fill_slot(DATA_W'($urandom), OFF); send_slot(1'b1, SLOT_W, 12, 1'b0);
      @(negedge clk);
      chk("midrst_no_valid", 32'(avalon_st_valid), 32'h0);
      chk("midrst_queue", exp_q.size(), 0);
      fill_slot(DATA_W'($urandom), OFF); send_slot(1'b0, SLOT_W, -1, 1'b0);
      fill_slot(DATA_W'($urandom), OFF); send_slot(1'b1, SLOT_W, -1, 1'b0);
      @(negedge clk);
      chk("midrst_drained", exp_q.size(), 0);

      rnd_ready = 1'b1;
      for (int s = 0; s < 6; s++) begin
         fill_slot(DATA_W'($urandom), OFF);
         send_slot(1'(s % 2 == 0 ? 0 : 1), SLOT_W, -1, 1'b0);
      end
      rnd_ready = 1'b0;
      tick();
      avalon_st_ready = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      chk("rand_drained", exp_q.size(), 0);
      chk("rand_overrun", 32'(overrun), 32'h0);

      fill_slot(DATA_W'($urandom), OFF); send_slot(1'b1, SLOT_W, -1, 1'b0);
      fill_slot(24'h800000, 0);
      slot_bits[DATA_W] = 1'b1;
      send_slot(1'b0, SLOT_W, -1, 1'b0);
      @(negedge clk);
      chk("fmt_data", 32'(avalon_st_data), LJ_EXP);
      chk("fmt_channel", 32'(avalon_st_channel), 32'h0);
      chk("final_drained", exp_q.size(), 0);
      chk("final_framing", 32'(framing_err), 32'(fe_exp));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ad1939_adc_deserializer.md
# ad1939_adc_deserializer

Receives the AD1939 ADC serial stream (bit clock, LR clock, serial data on the ASDATA2 line) and converts it to Avalon-ST stereo samples for the audio processing chain feeding the DAC path. Sits directly upstream of the FPGA audio datapath inside the soc_system fabric. All codec signals are oversampled in the system clock domain; no logic runs on the codec clocks.

## Interface
Parameters:
- DATA_W, 24, sample width delivered per channel (1..SLOT_W-1)
- SLOT_W, 32, BCLK periods per LRCLK half-period
- SYNC_STAGES, 2, synchronizer depth on each codec input (≥2)

Ports:
- clk  input  1  system clock; one clock, all logic on rising edge; must be ≥4× BCLK frequency
- reset  input  1  synchronous, active-high reset
- adc_bclk  input  1  codec ADC bit clock (asynchronous)
- adc_lrclk  input  1  codec ADC LR clock; 0 = left, 1 = right
- adc_sdata  input  1  codec ADC serial data, MSB first
- avalon_st_data  output  DATA_W  captured sample, two's complement
- avalon_st_channel  output  1  0 = left, 1 = right
- avalon_st_valid  output  1  sample available
- avalon_st_ready  input  1  downstream accept
- status_clear  input  1  clears sticky flags
- overrun  output  1  sticky: sample lost to backpressure
- framing_err  output  1  sticky: slot ended before DATA_W bits captured

## Operation
- Each codec input passes through SYNC_STAGES flops, then one edge-detect register; bclk_rise and lr_edge are single-cycle strobes.
- Bits sampled on bclk_rise only; lrclk value at lr_edge sets slot channel.
- FSM states: IDLE, DELAY, SHIFT, PAD.
  - IDLE: after reset; ignore data until first lr_edge -> DELAY (partial first frame discarded).
  - DELAY: skip one bclk_rise (I2S one-bit delay) -> SHIFT.
  - SHIFT: shift adc_sdata into shift register MSB first, count bits; on DATA_W-th bit load output register, -> PAD.
  - PAD: ignore remaining bits until lr_edge -> DELAY.
  - lr_edge in any state except IDLE restarts at DELAY; if in SHIFT, partial word discarded and framing_err set.
  - lr_edge coincident with the bclk_rise carrying the final bit: final bit taken, word completes, then restart.
- Output holding register, one entry: on word complete, data/channel loaded, valid set. valid clears on valid&&ready. If valid still set and not accepted in the same cycle as a new word completes: new word overwrites, valid stays high, overrun set. Completion in same cycle as acceptance: no overrun, new word presented.
- Sticky flags: set on event, cleared by status_clear; simultaneous set and clear -> set wins.
- Reset mid-frame: FSM to IDLE, holding register invalidated, next complete slot after the next lr_edge is the first output.

## Timing
- Reset values: avalon_st_data 0, avalon_st_channel 0, avalon_st_valid 0, overrun 0, framing_err 0; FSM IDLE; counters 0.
- Latency: valid asserts SYNC_STAGES+2 clk cycles after the clk edge at which the first sync flop captures the BCLK rise of the LSB.
- data/channel stable while valid high and not accepted, except on overrun overwrite.
- Throughput: one word per LRCLK half-period; no backpressure propagated to the codec.

## Configuration
- AD1939_ADC_LJ_EN defined: left-justified format; DELAY state bypassed, MSB captured on first bclk_rise after lr_edge.
- Not defined: I2S format, one-bit delay as above (default, matches codec power-up setting).

## Test plan
- I2S, DATA_W=24, SLOT_W=32, ready=1; left 0x123456, right 0xABCDEF -> outputs (0x123456, ch0) then (0xABCDEF, ch1), each valid one cycle, no flags.
- Reset released mid right slot -> right partial ignored; first output is next left word; valid 0 until then.
- ready=0 for two slots with left 0x000001, right 0x000002 -> valid held, data 0x000002 ch1, overrun=1; status_clear pulse -> overrun=0.
- LRCLK toggles after 10 bits of a slot -> no output for that slot, framing_err=1; following full slot delivers correctly.
- status_clear asserted in same cycle as overrun event -> overrun reads 1 next cycle.
- AD1939_ADC_LJ_EN defined, left 0x800000 left-justified -> output 0x800000 ch0; same stimulus without macro -> 0x000000-shifted mismatch (0x000000 plus bit from stream) confirming format select.
